// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the I/D memory port arbiter.
//   - arb_state_e : FSM state, encoded so that the state value is also the
//                   one-hot grant vector (00 idle, 01 I owns, 10 D owns).
//   - GNT_I_BIT / GNT_D_BIT : bit positions of each owner in the grant vector.
//   - STREAK_W    : width of the D-streak (starvation) counter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_I = 2'b01,
        ARB_GNT_D = 2'b10
    } arb_state_e;

    localparam int GNT_I_BIT = 0;
    localparam int GNT_D_BIT = 1;

    // Holds STARVE_LIMIT values up to 15.
    localparam int STREAK_W  = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// arb_starve_ctr
//   Saturating count of D transactions completed while the I-cache was
//   waiting. When the count reaches STARVE_LIMIT the arbiter lets I win the
//   next simultaneous request.
//   Ports:
//     clk, clrn   : clock, asynchronous active-low reset
//     inc_i       : a D transaction completed while I was requesting
//     clr_i       : restart the streak (I granted, or I not requesting)
//     at_limit_o  : streak has reached STARVE_LIMIT
module arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4   // legal range 1..15
) (
    input  logic clk,
    input  logic clrn,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (clr_i)
            streak_d = '0;
        else if (inc_i && (streak_q != LIMIT))
            streak_d = streak_q + 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            streak_q <= '0;
        else
            streak_q <= streak_d;
    end

    assign at_limit_o = (streak_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction cache (reads only) and
//   the write-through data cache (read misses and all writes). One
//   transaction at a time, strobe/ready handshake on every side. D has
//   priority; after STARVE_LIMIT back-to-back D completions with I waiting,
//   I is forced ahead of D.
//   Ports:
//     clk, clrn                 : clock, asynchronous active-low reset
//     i_a, i_strobe             : I-cache read request
//     i_din, i_ready            : I-cache read data / completion pulse
//     d_a, d_dout, d_rw, d_strobe : D-cache request (d_rw 1 = write)
//     d_din, d_ready            : D-cache read data / completion pulse
//     m_a, m_din, m_rw, m_strobe : memory request
//     m_dout, m_ready           : memory read data / completion pulse
//     grant                     : 01 I owns port, 10 D owns port, 00 idle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int A_WIDTH      = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               clrn,
    // I-cache side
    input  logic [A_WIDTH-1:0] i_a,
    input  logic               i_strobe,
    output logic [31:0]        i_din,
    output logic               i_ready,
    // D-cache side
    input  logic [A_WIDTH-1:0] d_a,
    input  logic [31:0]        d_dout,
    input  logic               d_rw,
    input  logic               d_strobe,
    output logic [31:0]        d_din,
    output logic               d_ready,
    // memory side
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    output logic               m_rw,
    output logic               m_strobe,
    input  logic [31:0]        m_dout,
    input  logic               m_ready,
    // status
    output logic [1:0]         grant
);

    arb_state_e state_q, state_d;
    logic       at_limit;
    logic       starve_inc;
    logic       starve_clr;

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
    // Count D completions that happened while I was still waiting; restart
    // whenever I gets the port or stops asking.
    assign starve_inc = (state_q == ARB_GNT_D) && m_ready && i_strobe;
    assign starve_clr = (state_q == ARB_IDLE) &&
                        (!i_strobe || (state_d == ARB_GNT_I));

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .clrn       (clrn),
        .inc_i      (starve_inc),
        .clr_i      (starve_clr),
        .at_limit_o (at_limit)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    // Every grant returns to IDLE, which gives the mandatory bubble between
    // transactions (even for the same requester).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_strobe && (!d_strobe || at_limit))
                    state_d = ARB_GNT_I;
                else if (d_strobe)
                    state_d = ARB_GNT_D;
            end
            ARB_GNT_I: begin
                // completion, or I withdrew its request
                if (m_ready || !i_strobe)
                    state_d = ARB_IDLE;
            end
            ARB_GNT_D: begin
                if (m_ready || !d_strobe)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Port mux
    // ------------------------------------------------------------------
    // Request-side outputs depend only on the registered owner and the
    // owner's own inputs, so m_ready never reaches m_strobe/m_a/m_rw.
    always_comb begin
        m_strobe = 1'b0;
        m_rw     = 1'b0;
        m_a      = '0;
        m_din    = '0;
        i_ready  = 1'b0;
        d_ready  = 1'b0;
        case (state_q)
            ARB_GNT_I: begin
                m_strobe = i_strobe;
                m_a      = i_a;
                i_ready  = m_ready;
            end
            ARB_GNT_D: begin
                m_strobe = d_strobe;
                m_a      = d_a;
                m_din    = d_dout;
                m_rw     = d_rw;
                d_ready  = m_ready;
            end
            default: ;
        endcase
    end

    assign grant = state_q;

    // Read data goes to both sides; each cache only takes it with its ready.
    assign i_din = m_dout;
    assign d_din = m_dout;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single memory port between the instruction cache (read-only) and the write-through data cache (reads on miss, every write). Sits between the cache pair and the memory/bus bridge, uses the same strobe/ready handshake on all sides, and sequences one transaction at a time. Data side has priority, and a bounded starvation guard protects instruction fetch.

## Interface
- A_WIDTH, 32: address width on all ports.
- STARVE_LIMIT, 4: back-to-back D transactions completed while I waits before I is forced; legal range 1..15.
- clk  in  1  clock.
- clrn  in  1  reset, asynchronous, active-low.
- i_a  in  A_WIDTH  I-cache read address.
- i_strobe  in  1  I-cache request; held until i_ready.
- i_din  out  32  read data to I-cache (= m_dout).
- i_ready  out  1  I transaction complete, single cycle.
- d_a  in  A_WIDTH  D-cache address.
- d_dout  in  32  D-cache write data.
- d_rw  in  1  0 read, 1 write.
- d_strobe  in  1  D-cache request; held until d_ready.
- d_din  out  32  read data to D-cache (= m_dout).
- d_ready  out  1  D transaction complete, single cycle.
- m_a  out  A_WIDTH  memory address.
- m_din  out  32  memory write data.
- m_rw  out  1  memory write enable.
- m_strobe  out  1  memory request.
- m_dout  in  32  memory read data.
- m_ready  in  1  memory completion pulse.
- grant  out  2  01 = I owns port, 10 = D owns port, 00 = idle.

## Operation
- FSM states: IDLE, GNT_I, GNT_D; encoding 2-bit one-hot on grant.
- IDLE decision (registered into next state):
  - i_strobe & (~d_strobe | streak == STARVE_LIMIT) -> GNT_I.
  - else d_strobe -> GNT_D.
  - else stay IDLE.
- GNT_x: m_strobe = x_strobe; m_a, m_din, m_rw muxed from owner; m_rw = 0 in GNT_I.
- GNT_x, m_ready = 1 -> x_ready = 1 same cycle; next state IDLE.
- GNT_x, owner drops strobe without m_ready -> next state IDLE, no ready issued.
- In IDLE: m_strobe = 0, m_rw = 0, m_a = 0, m_din = 0, both readies 0.
- m_ready in IDLE, or non-owner side: ignored; ready never routed to non-owner.
- streak counter, 4-bit, saturating at STARVE_LIMIT:
  - +1 when a GNT_D transaction completes with i_strobe = 1.
  - cleared on entry to GNT_I and whenever i_strobe = 0 in IDLE.
- i_din, d_din are continuous copies of m_dout; only meaningful while own ready = 1.

## Timing
- Reset values: state IDLE, grant 00, streak 0, m_strobe/m_rw/i_ready/d_ready 0, m_a/m_din 0. Reset is asynchronous; mid-transaction reset drops m_strobe immediately.
- Request in IDLE at cycle t -> grant and m_strobe at t+1.
- Minimum transaction (m_ready at t+1) -> ready at t+1; port IDLE at t+2; next grant at t+3.
- One mandatory IDLE bubble between any two transactions, including same requester.
- Simultaneous i_strobe and d_strobe in IDLE: D wins unless streak == STARVE_LIMIT.
- Worst-case I wait: STARVE_LIMIT D transactions plus bubbles.
- No combinational path from m_ready to m_strobe/m_a/m_rw.

## Structure
- Shared package: state/grant localparams (ARB_IDLE, ARB_GNT_I, ARB_GNT_D), grant bit indices.
- One sub-module: arb_starve_ctr (saturating streak counter with inc/clear/limit compare, STARVE_LIMIT parameter).
- Output mux and FSM in top level.

## Test plan
- Reset then d_strobe read at 0x0000_0100, m_ready after 3 cycles -> grant=10 at t+1, m_strobe held 3 cycles, d_ready pulse 1 cycle with d_din=m_dout=0xDEADBEEF, grant=00 next.
- i_strobe and d_strobe rise same cycle, both held -> D served first, bubble, then I; i_ready once, d_ready once.
- i_strobe held, d_strobe continuously re-asserted, STARVE_LIMIT=4 -> exactly 4 D completions, then GNT_I; streak returns 0.
- D write, d_rw=1, d_a=0x0000_0040, d_dout=0x12345678 -> m_rw=1, m_a=0x0000_0040, m_din=0x12345678 until m_ready; i_ready stays 0.
- clrn low while GNT_D with m_strobe=1 -> m_strobe, grant, d_ready 0 immediately; after release, pending i_strobe granted at t+1.
- Stray m_ready in IDLE and owner strobe withdrawal mid-GNT_I -> no ready pulses, FSM back to IDLE.
